// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter: data priority, fetch starvation guard, tagged read return
module mem_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              rd_pend_q;
    logic              rd_tag_q;
    logic              if_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    // Fetch only overrides data once it has been denied STARVE_LIMIT cycles in a row.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (d_req && !(if_req && starve_cnt_q == LIMIT)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        mem_re    = if_gnt | (d_gnt & ~d_we);
        mem_we    = d_gnt & d_we;
        mem_wdata = d_wdata;
        mem_addr  = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            rd_pend_q    <= 1'b0;
            rd_tag_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= mem_re;
            rd_tag_q     <= d_gnt;
            if_rvalid_q  <= rd_pend_q & ~rd_tag_q;
            d_rvalid_q   <= rd_pend_q & rd_tag_q;
            // rdata holds between responses; only the owning side captures.
            if (rd_pend_q && !rd_tag_q) begin
                if_rdata_q <= mem_rdata;
            end
            if (rd_pend_q && rd_tag_q) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int AW = 24;
    localparam int DW = 24;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, mem_re;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro: registered read, write visible to a read on the next edge.
    logic [DW-1:0] mem_arr [64];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[5:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_arr[mem_addr[5:0]];
    end

    function automatic logic [DW-1:0] init_val(input int a);
        case (a)
            0:       return 24'hDEADBE;
            3:       return 24'hFEEDBA;
            9:       return 24'hC0FFEE;
            default: return 24'((a * 32'h1357) ^ 32'h5A5A5A);
        endcase
    endfunction

    typedef struct {
        bit            own_d;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          rq[$];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_if_rdata, exp_d_rdata;
    int            denied;
    int            cyc;
    int            n_tests, n_fail;
    bit            last_if_gnt, last_d_gnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit ir, input logic [AW-1:0] ia,
                         input bit dr, input bit dw, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd);
        bit eg_if, eg_d, ev_if, ev_d;
        logic [AW-1:0] ea;
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        #1;
        eg_if = 0; eg_d = 0;
        if (!r) begin
            if (ir && dr) begin
                if (denied >= LIM) eg_if = 1; else eg_d = 1;
            end else if (ir) eg_if = 1;
            else if (dr) eg_d = 1;
        end
        ea = eg_if ? ia : (eg_d ? da : '0);
        check_eq("if_gnt", 32'(if_gnt), 32'(eg_if));
        check_eq("d_gnt", 32'(d_gnt), 32'(eg_d));
        check_eq("mem_re", 32'(mem_re), 32'(eg_if | (eg_d & !dw)));
        check_eq("mem_we", 32'(mem_we), 32'(eg_d & dw));
        check_eq("mem_addr", 32'(mem_addr), 32'(ea));
        if (eg_d && dw) check_eq("mem_wdata", 32'(mem_wdata), 32'(dwd));
        ev_if = 0; ev_d = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].own_d) begin ev_d = 1; exp_d_rdata = rq[0].data; end
            else begin ev_if = 1; exp_if_rdata = rq[0].data; end
            void'(rq.pop_front());
        end
        check_eq("if_rvalid", 32'(if_rvalid), 32'(ev_if));
        check_eq("d_rvalid", 32'(d_rvalid), 32'(ev_d));
        check_eq("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
        check_eq("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
        if (eg_if) rq.push_back('{0, ref_mem[ia[5:0]], cyc + 2});
        if (eg_d && !dw) rq.push_back('{1, ref_mem[da[5:0]], cyc + 2});
        if (eg_d && dw) ref_mem[da[5:0]] = dwd;
        if (r || !ir || eg_if) denied = 0;
        else if (denied < LIM) denied++;
        if (r) begin
            rq.delete();
            exp_if_rdata = '0;
            exp_d_rdata = '0;
        end
        last_if_gnt = eg_if;
        last_d_gnt = eg_d;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    bit            ip, dp, dwv;
    logic [AW-1:0] ia_v, da_v;
    logic [DW-1:0] dwd_v;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; denied = 0;
        exp_if_rdata = '0; exp_d_rdata = '0;
        for (int a = 0; a < 64; a++) begin
            mem_arr[a] = init_val(a);
            ref_mem[a] = init_val(a);
        end
        rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        @(posedge clk);

        // Reset with traffic, then first grant must go to data
        cycle(1, 1, 0, 1, 0, 9, 0);
        cycle(1, 1, 0, 1, 0, 9, 0);
        cycle(0, 1, 0, 1, 0, 9, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        // Single fetch
        cycle(0, 1, 24'h000003, 0, 0, 0, 0);
        idle(3);
        // Starvation: both held continuously
        for (int i = 0; i < 12; i++) cycle(0, 1, 24'h000004, 1, 0, 24'h000009, 0);
        idle(3);
        // Write then read same address
        cycle(0, 0, 0, 1, 1, 24'h000010, 24'hABCDEF);
        cycle(0, 0, 0, 1, 0, 24'h000010, 0);
        idle(3);
        // Reset mid-read
        cycle(0, 1, 24'h000003, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(4);

        ip = 0; dp = 0; dwv = 0; ia_v = 0; da_v = 0; dwd_v = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!ip) begin
                ip = ($urandom_range(0, 9) < 7);
                ia_v = AW'($urandom_range(0, 63));
            end
            if (!dp) begin
                dp = ($urandom_range(0, 9) < 6);
                dwv = $urandom_range(0, 2) == 0;
                da_v = AW'($urandom_range(0, 63));
                dwd_v = DW'($urandom);
            end
            cycle(($urandom_range(0, 99) < 2), ip, ia_v, dp, dwv, da_v, dwd_v);
            if (last_if_gnt) ip = 0;
            if (last_d_gnt) dp = 0;
        end
        idle(4);
        check_eq("queue_drained", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared byte-addressed memory port, with 24-bit words and a one-cycle registered read, between the instruction-fetch requester and the data load/store requester of the MIPS-24 core. It accepts at most one access per cycle. Data has fixed priority over fetch, and a starvation guard limits how long fetch can be blocked. Read responses are pipelined: each is tagged at issue and returned to its owner two cycles after acceptance. The block sits between the fetch/decode control, the load/store control, and the single memory macro.

## Interface
- ADDR_W, 24, byte address width passed unchanged to memory
- DATA_W, 24, word width
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins; range 1..15
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  DATA_W  fetch read data (registered)
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  data read data valid (registered)
- d_rdata  out  DATA_W  data read data (registered)
- mem_addr  out  ADDR_W  memory address, from the granted requester
- mem_wdata  out  DATA_W  memory write data, equal to d_wdata
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, valid in the cycle after mem_re

## Operation
- **Accept rule:** a request is accepted on the edge that ends a cycle in which req and gnt are both high. Requesters hold addr, we and wdata stable until granted.
- **Arbitration, evaluated every cycle while rst is low:**
  - only d_req: d_gnt=1.
  - only if_req: if_gnt=1.
  - both requesting, starve_cnt < STARVE_LIMIT: d_gnt=1.
  - both requesting, starve_cnt == STARVE_LIMIT: if_gnt=1.
  - never both gnt in the same cycle.
- **starve_cnt (4-bit):**
  - cleared on reset, on an if_gnt cycle, or when if_req is low.
  - incremented when if_req=1 and if_gnt=0.
  - saturates at STARVE_LIMIT.
- **Memory command (combinational in the accept cycle):**
  - mem_re = (if_gnt) | (d_gnt & ~d_we).
  - mem_we = d_gnt & d_we.
  - mem_addr comes from the granted side.
  - with no grant: mem_addr = 0 and mem_re = mem_we = 0.
- **Response pipeline:**
  - Stage 1 register: rd_pend (1 bit) and rd_tag (0 = fetch, 1 = data), loaded with mem_re and the owner on every edge.
  - Stage 2: on the edge after stage 1, if rd_pend is set, mem_rdata is captured into the owner's rdata and the owner's rvalid is set for exactly one cycle. The other side's rvalid is 0.
  - rdata holds its last value when rvalid is 0.
- **Writes:** produce no rvalid. A read issued on the cycle after a write to the same address returns the written data; the memory's ordering guarantees this.
- **Address handling:** no range check and no alignment enforcement. Address wrap-around (addr+2 past 2^ADDR_W-1) is the memory's concern.

## Timing
- **Reset values:**
  - if_rvalid = d_rvalid = 0 and if_rdata = d_rdata = 0.
  - rd_pend = 0 and starve_cnt = 0.
  - while rst is high: if_gnt = d_gnt = 0, mem_re = mem_we = 0, mem_addr = 0.
- **Read latency:** accept in cycle N, mem_rdata valid in N+1, rvalid and rdata high in N+2.
- **Throughput:** one access per cycle. Back-to-back reads give back-to-back rvalid in issue order.
- **Reset mid-operation:** an edge with rst high clears stage 1 and stage 2. Any in-flight read never produces rvalid, and a write accepted in the cycle before reset still completes at the memory.
- **Simultaneous events:** an rvalid for an earlier read and a new grant in the same cycle are independent and both occur.

## Test plan
- **Reset with traffic:** rst high for 2 cycles with if_req = d_req = 1 -> if_gnt = d_gnt = mem_re = mem_we = 0, both rvalid = 0. The first grant after deassert goes to data.
- **Single fetch:** if_req at addr 0x000003, memory model returns 0xFEEDBA -> cycle 0: if_gnt = 1, mem_re = 1, mem_addr = 0x000003. Cycle 2: if_rvalid = 1, if_rdata = 0xFEEDBA, d_rvalid = 0.
- **Contention:** if_req at 0x000000 and d_req read at 0x000009 in the same cycle -> d_gnt in cycle 0 and if_gnt in cycle 1. d_rvalid = 0xC0FFEE in cycle 2, if_rvalid = 0xDEADBE in cycle 3.
- **Starvation (STARVE_LIMIT = 4):** d_req and if_req held continuously -> d_gnt in cycles 0-3, if_gnt in cycle 4, d_gnt from cycle 5 onward, if_gnt again in cycle 9.
- **Write then read:** data write 0xABCDEF to 0x000010, then data read of 0x000010 -> mem_we = 1 with no rvalid, then d_rvalid = 1 with d_rdata = 0xABCDEF two cycles after the read grant.
- **Reset mid-read:** fetch read accepted in cycle 0, rst high in cycle 1 -> if_rvalid stays 0 through cycle 4, and if_rdata = 0 after reset.
